// File: rtl/pixel.sv
// Packs the camera byte stream into 16-bit SRAM words, frames capture on VSYNC and stops at JPEG EOI.
// Optional macro PIXEL_SPLIT_EOI_EN also detects an EOI marker split across two consecutive words.
module pixel #(
    parameter logic VSYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pixel_addr,
    input  logic [7:0]  pixel_data,
    input  logic        pixel_WE,
    input  logic        pixel_vsync,
    input  logic        sram_ready,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_data,
    output logic        sram_rw,
    output logic        sram_start,
    output logic        frame_end,
    output logic        error,
    output logic        pixel_capture_reset,
    output logic [15:0] stop_addr
);

    localparam logic [1:0] G_WAIT_FRAME_END = 2'd0;
    localparam logic [1:0] G_WAIT_FRAME     = 2'd1;
    localparam logic [1:0] G_CAPTURE        = 2'd2;

    localparam logic [2:0] L_WAIT_FIRST     = 3'd0;
    localparam logic [2:0] L_WAIT_FIRST_END = 3'd1;
    localparam logic [2:0] L_WAIT_SECOND    = 3'd2;
    localparam logic [2:0] L_START_WRITE    = 3'd3;
    localparam logic [2:0] L_END_WRITE      = 3'd4;

    logic [1:0]  gstate;
    logic [2:0]  lstate;
    logic [15:0] prev_word;
    logic        vsync_active;
    logic        is_eoi;
    logic        unused_addr_lsb;

    assign vsync_active    = (pixel_vsync == VSYNC_ACTIVE);
    assign sram_rw         = 1'b0;
    // Word address is taken from the first byte, so its byte-select bit is dropped.
    assign unused_addr_lsb = pixel_addr[0];

`ifdef PIXEL_SPLIT_EOI_EN
    assign is_eoi = (sram_data == 16'hD9FF) ||
                    ((prev_word[15:8] == 8'hFF) && (sram_data[7:0] == 8'hD9));
`else
    assign is_eoi = (sram_data == 16'hD9FF);
`endif

    // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_addr           <= 16'h0000;
            sram_data           <= 16'h0000;
            sram_start          <= 1'b1;
            frame_end           <= 1'b0;
            error               <= 1'b0;
            pixel_capture_reset <= 1'b0;
            stop_addr           <= 16'h0000;
            prev_word           <= 16'h0000;
            gstate              <= G_WAIT_FRAME_END;
            lstate              <= L_WAIT_FIRST;
        end else begin
            case (gstate)
                G_WAIT_FRAME_END: begin
                    pixel_capture_reset <= 1'b0;
                    if (vsync_active) gstate <= G_WAIT_FRAME;
                end
                G_WAIT_FRAME: begin
                    pixel_capture_reset <= 1'b0;
                    if (!vsync_active) begin
                        pixel_capture_reset <= 1'b1;
                        frame_end           <= 1'b0;
                        prev_word           <= 16'h0000;
                        lstate              <= L_WAIT_FIRST;
                        gstate              <= G_CAPTURE;
                    end
                end
                G_CAPTURE: begin
                    case (lstate)
                        L_WAIT_FIRST: begin
                            if (vsync_active) begin
                                error               <= 1'b1;
                                pixel_capture_reset <= 1'b0;
                                gstate              <= G_WAIT_FRAME;
                            end else if (pixel_WE) begin
                                sram_data[7:0] <= pixel_data;
                                sram_addr      <= {1'b0, pixel_addr[15:1]};
                                lstate         <= L_WAIT_FIRST_END;
                            end
                        end
                        L_WAIT_FIRST_END: begin
                            if (!pixel_WE) lstate <= L_WAIT_SECOND;
                        end
                        L_WAIT_SECOND: begin
                            if (pixel_WE) begin
                                sram_data[15:8] <= pixel_data;
                                lstate          <= L_START_WRITE;
                            end
                        end
                        L_START_WRITE: begin
                            sram_start <= 1'b0;
                            lstate     <= L_END_WRITE;
                        end
                        L_END_WRITE: begin
                            sram_start <= 1'b1;
                            // Wait for the SRAM to finish and the capture side to release WE.
                            if (sram_ready && !pixel_WE) begin
                                lstate <= L_WAIT_FIRST;
                                if (is_eoi) begin
                                    stop_addr           <= sram_addr;
                                    frame_end           <= 1'b1;
                                    pixel_capture_reset <= 1'b0;
                                    gstate              <= G_WAIT_FRAME;
                                end else begin
                                    prev_word <= sram_data;
                                end
                            end
                        end
                        default: lstate <= L_WAIT_FIRST;
                    endcase
                end
                default: gstate <= G_WAIT_FRAME_END;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel.sv
// Self-checking bench for pixel: a timing-rule scoreboard predicts every output each cycle.
// Build with or without PIXEL_SPLIT_EOI_EN; the bench follows the same macro.
module tb_pixel;

`ifdef PIXEL_SPLIT_EOI_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pixel_addr;
    logic [7:0]  pixel_data;
    logic        pixel_WE;
    logic        pixel_vsync;
    logic        sram_ready;
    logic [15:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_rw;
    logic        sram_start;
    logic        frame_end;
    logic        error;
    logic        pixel_capture_reset;
    logic [15:0] stop_addr;

    pixel dut (
        .clk                 (clk),
        .reset               (reset),
        .pixel_addr          (pixel_addr),
        .pixel_data          (pixel_data),
        .pixel_WE            (pixel_WE),
        .pixel_vsync         (pixel_vsync),
        .sram_ready          (sram_ready),
        .sram_addr           (sram_addr),
        .sram_data           (sram_data),
        .sram_rw             (sram_rw),
        .sram_start          (sram_start),
        .frame_end           (frame_end),
        .error               (error),
        .pixel_capture_reset (pixel_capture_reset),
        .stop_addr           (stop_addr)
    );

    always #5 clk = ~clk;

    // Expected outputs, updated by the stimulus process right after each rising edge.
    logic [15:0] exp_addr, exp_data, exp_stop;
    logic        exp_start, exp_fe, exp_err, exp_pcr;
    logic [15:0] model_prev;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("sram_addr",  sram_addr, exp_addr);
            check("sram_data",  sram_data, exp_data);
            check("stop_addr",  stop_addr, exp_stop);
            check("sram_start", {15'd0, sram_start}, {15'd0, exp_start});
            check("sram_rw",    {15'd0, sram_rw}, 16'd0);
            check("frame_end",  {15'd0, frame_end}, {15'd0, exp_fe});
            check("error",      {15'd0, error}, {15'd0, exp_err});
            check("pcr",        {15'd0, pixel_capture_reset}, {15'd0, exp_pcr});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset();
        exp_addr = 16'h0; exp_data = 16'h0; exp_stop = 16'h0;
        exp_start = 1'b1; exp_fe = 1'b0; exp_err = 1'b0; exp_pcr = 1'b0;
        model_prev = 16'h0;
    endtask

    // VSYNC active for two edges, then inactive: the capture block is released on that edge.
    task automatic frame_start();
        pixel_WE = 1'b0;
        pixel_vsync = 1'b0;
        repeat (2) cyc();
        pixel_vsync = 1'b1;
        cyc();
        exp_pcr = 1'b1;
        exp_fe = 1'b0;
        model_prev = 16'h0;
    endtask

    // One word: WE high h1/low l1 for the first byte, high h2 for the second, SRAM busy rdly
    // edges after the strobe. A frame's last word drops VSYNC right after its second byte.
    task automatic send_word(input logic [15:0] addr, input logic [7:0] b0, input logic [7:0] b1,
                             input int h1, input int l1, input int h2, input int rdly,
                             input bit last, output bit fired);
        bit          done;
        logic [15:0] word;
        bit          eoi;
        pixel_WE = 1'b1; pixel_addr = addr; pixel_data = b0;
        for (int i = 0; i < h1; i++) begin
            cyc();
            if (i == 0) begin
                exp_addr = addr >> 1;
                exp_data[7:0] = b0;
            end
            pixel_addr = 16'($urandom);
        end
        pixel_WE = 1'b0; pixel_data = 8'($urandom);
        repeat (l1) cyc();
        pixel_WE = 1'b1; pixel_data = b1; pixel_addr = 16'($urandom);
        cyc();
        exp_data[15:8] = b1;
        if (last) pixel_vsync = 1'b0;
        done = 1'b0;
        for (int k = 1; !done; k++) begin
            pixel_WE   = (k < h2);
            sram_ready = !(k >= 2 && k < 2 + rdly);
            done = (k >= 2) && !pixel_WE && sram_ready;
            cyc();
            if (k == 1) exp_start = 1'b0;
            if (k == 2) exp_start = 1'b1;
        end
        word = {b1, b0};
        eoi = (word == 16'hD9FF) || (SPLIT && model_prev[15:8] == 8'hFF && b0 == 8'hD9);
        if (eoi) begin
            exp_stop = addr >> 1;
            exp_fe = 1'b1;
            exp_pcr = 1'b0;
        end else begin
            model_prev = word;
        end
        fired = eoi;
        pixel_WE = 1'b0;
        sram_ready = 1'b1;
        if (!eoi && last) begin
            cyc();
            exp_err = 1'b1;
            exp_pcr = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          fired;
        int          nwords, kind;
        logic [15:0] base;
        logic [7:0]  b0, b1;

        reset = 1'b1; pixel_addr = 16'h0; pixel_data = 8'h0; pixel_WE = 1'b0;
        pixel_vsync = 1'b1; sram_ready = 1'b1;
        cyc();
        expect_reset();
        chk_en = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();

        // Frame start releases the capture block.
        frame_start();
        check("lit_pcr_rise", {15'd0, pixel_capture_reset}, 16'd1);

        // Basic packing.
        send_word(16'h0004, 8'h12, 8'h34, 1, 1, 1, 0, 1'b0, fired);
        check("lit_addr", sram_addr, 16'h0002);
        check("lit_data", sram_data, 16'h3412);

        // VSYNC active in WAIT_FIRST mid-frame.
        pixel_vsync = 1'b0;
        cyc();
        exp_err = 1'b1; exp_pcr = 1'b0;
        check("lit_error", {15'd0, error}, 16'd1);
        check("lit_err_pcr", {15'd0, pixel_capture_reset}, 16'd0);
        frame_start();
        check("lit_error_sticky", {15'd0, error}, 16'd1);

        // In-word EOI.
        send_word(16'h0020, 8'hFF, 8'hD9, 2, 1, 2, 0, 1'b1, fired);
        check("lit_stop", stop_addr, 16'h0010);
        check("lit_fe", {15'd0, frame_end}, 16'd1);
        check("lit_eoi_pcr", {15'd0, pixel_capture_reset}, 16'd0);
        frame_start();
        check("lit_fe_clear", {15'd0, frame_end}, 16'd0);

        // EOI split across words.
        send_word(16'h0040, 8'h00, 8'hFF, 1, 1, 1, 0, 1'b0, fired);
        send_word(16'h0042, 8'hD9, 8'h00, 1, 1, 1, 0, 1'b1, fired);
        check("lit_split_fe", {15'd0, frame_end}, {15'd0, SPLIT});
        check("lit_split_stop", stop_addr, SPLIT ? 16'h0021 : 16'h0010);

        // SRAM busy for 5 edges after the strobe.
        frame_start();
        send_word(16'h0100, 8'h55, 8'h66, 1, 2, 1, 5, 1'b0, fired);
        check("lit_stall_data", sram_data, 16'h6655);
        check("lit_stall_addr", sram_addr, 16'h0080);

        // Reset while the write strobe is low.
        pixel_WE = 1'b1; pixel_addr = 16'h0040; pixel_data = 8'hAA;
        cyc();
        exp_addr = 16'h0020; exp_data[7:0] = 8'hAA;
        pixel_WE = 1'b0;
        cyc();
        pixel_WE = 1'b1; pixel_data = 8'hBB;
        cyc();
        exp_data[15:8] = 8'hBB;
        pixel_WE = 1'b0;
        cyc();
        exp_start = 1'b0;
        reset = 1'b1;
        cyc();
        expect_reset();
        reset = 1'b0;
        check("lit_abort_start", {15'd0, sram_start}, 16'd1);
        check("lit_abort_data", sram_data, 16'h0000);

        // Randomised frames: mid-frame words never form an EOI; the last word may.
        for (int f = 0; f < 30; f++) begin
            frame_start();
            nwords = $urandom_range(1, 8);
            kind   = $urandom_range(0, 2);
            base   = {15'($urandom), 1'b0};
            for (int w = 0; w < nwords; w++) begin
                b0 = 8'($urandom);
                b1 = 8'($urandom);
                if (b0 == 8'hD9) b0 = 8'hD8;
                if (b1 == 8'hD9) b1 = 8'hD8;
                if (w == nwords - 2 && kind == 1) b1 = 8'hFF;
                if (w == nwords - 1 && kind == 0) begin b0 = 8'hFF; b1 = 8'hD9; end
                if (w == nwords - 1 && kind == 1) b0 = 8'hD9;
                send_word(base + 16'(2 * w), b0, b1, $urandom_range(1, 3), $urandom_range(1, 3),
                          $urandom_range(1, 3), $urandom_range(0, 4), w == nwords - 1, fired);
            end
        end

        repeat (2) cyc();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
